stream_pause_gate: RTL and testbench

//  Forward-path stage placed directly upstream of the turnaround stage. Forwards beats one cycle

---
 rtl/stream_pause_gate.sv | 177 +++++++++++++++++
 tb/tb_stream_pause_gate.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pause_gate.sv
// Forward-path pause gate: registers beats toward the turnaround stage, drops whole packets of
// paused streams, and consumes PAUSE/RESUME instructions addressed to this gate's channel.
module stream_pause_gate #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int STATE_WIDTH                 = 32,
  parameter int INSTRUCTION_WIDTH           = 2,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter int INSTRUCTION_CMD_IDLE        = 0,
  parameter int INSTRUCTION_CMD_PAUSE       = 1,
  parameter int INSTRUCTION_CMD_RESUME      = 2,
  parameter int GATE_CHANNEL_ID             = 1023,
  parameter int DROP_COUNT_WIDTH            = 16,
  localparam int STREAM_ID_WIDTH            = $clog2(STREAM_ID_NUM),
  localparam int CHUNK_ID_WIDTH             = $clog2(CHUNK_ID_NUM),
  localparam int CHANNEL_ID_WIDTH           = $clog2(CHANNEL_ID_NUM)
) (
  input  logic                                   clk,
  input  logic                                   rstIn,
  input  logic [DATA_WIDTH-1:0]                  front_Data,
  input  logic [1:0]                             front_Type,
  input  logic                                   front_Last,
  input  logic [STREAM_ID_WIDTH-1:0]             front_StreamID,
  input  logic [CHUNK_ID_WIDTH-1:0]              front_ChunkID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            front_ChannelID,
  input  logic [STATE_WIDTH-1:0]                 front_State,
  output logic [DATA_WIDTH-1:0]                  back_Data,
  output logic [1:0]                             back_Type,
  output logic                                   back_Last,
  output logic [STREAM_ID_WIDTH-1:0]             back_StreamID,
  output logic [CHUNK_ID_WIDTH-1:0]              back_ChunkID,
  output logic [CHANNEL_ID_WIDTH-1:0]            back_ChannelID,
  output logic [STATE_WIDTH-1:0]                 back_State,
  input  logic [INSTRUCTION_WIDTH-1:0]           back_InstructionType,
  input  logic [STREAM_ID_WIDTH-1:0]             back_InstructionStreamID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            back_InstructionChannelID,
  input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] back_InstructionParameter,
  output logic [INSTRUCTION_WIDTH-1:0]           front_InstructionType,
  output logic [STREAM_ID_WIDTH-1:0]             front_InstructionStreamID,
  output logic [CHANNEL_ID_WIDTH-1:0]            front_InstructionChannelID,
  output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] front_InstructionParameter,
  output logic [STREAM_ID_NUM-1:0]               pausedMask,
  output logic [DROP_COUNT_WIDTH-1:0]            dropCount
);

  localparam logic [INSTRUCTION_WIDTH-1:0] CMD_IDLE   = INSTRUCTION_WIDTH'(INSTRUCTION_CMD_IDLE);
  localparam logic [INSTRUCTION_WIDTH-1:0] CMD_PAUSE  = INSTRUCTION_WIDTH'(INSTRUCTION_CMD_PAUSE);
  localparam logic [INSTRUCTION_WIDTH-1:0] CMD_RESUME = INSTRUCTION_WIDTH'(INSTRUCTION_CMD_RESUME);
  localparam logic [CHANNEL_ID_WIDTH-1:0]  GATE_CH    = CHANNEL_ID_WIDTH'(GATE_CHANNEL_ID);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

  function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(input logic [DROP_COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                                 state_q, state_d;
  logic [DATA_WIDTH-1:0]                  data_q;
  logic [1:0]                             type_q;
  logic                                   last_q;
  logic [STREAM_ID_WIDTH-1:0]             sid_q;
  logic [CHUNK_ID_WIDTH-1:0]              cid_q;
  logic [CHANNEL_ID_WIDTH-1:0]            chid_q;
  logic [STATE_WIDTH-1:0]                 st_q;
  logic [INSTRUCTION_WIDTH-1:0]           ins_type_q;
  logic [STREAM_ID_WIDTH-1:0]             ins_sid_q;
  logic [CHANNEL_ID_WIDTH-1:0]            ins_chid_q;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] ins_par_q;
  logic [STREAM_ID_NUM-1:0]               mask_q, mask_d;
  logic [DROP_COUNT_WIDTH-1:0]            cnt_q, cnt_d;
  logic                                   beat_vld, pass_beat, drop_done, ins_consume;

  // Packet decision: only the first beat of a packet looks at the (registered) pause mask.
  always_comb begin
    beat_vld  = (front_Type != 2'b00);
    state_d   = state_q;
    pass_beat = 1'b0;
    drop_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat_vld) begin
          if (!mask_q[front_StreamID]) begin
            pass_beat = 1'b1;
            if (!front_Last) state_d = ST_PASS;
          end else if (front_Last) begin
            drop_done = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (beat_vld) begin
          pass_beat = 1'b1;
          if (front_Last) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (beat_vld && front_Last) begin
          drop_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = drop_done ? sat_inc(cnt_q) : cnt_q;
  end

  always_comb begin
    ins_consume = ((back_InstructionType == CMD_PAUSE) || (back_InstructionType == CMD_RESUME)) &&
                  (back_InstructionChannelID == GATE_CH);
    mask_d = mask_q;
    if (ins_consume) mask_d[back_InstructionStreamID] = (back_InstructionType == CMD_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (rstIn) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      type_q     <= '0;
      last_q     <= 1'b0;
      sid_q      <= '0;
      cid_q      <= '0;
      chid_q     <= '0;
      st_q       <= '0;
      ins_type_q <= CMD_IDLE;
      ins_sid_q  <= '0;
      ins_chid_q <= '0;
      ins_par_q  <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      if (pass_beat) begin
        data_q <= front_Data;
        type_q <= front_Type;
        last_q <= front_Last;
        sid_q  <= front_StreamID;
        cid_q  <= front_ChunkID;
        chid_q <= front_ChannelID;
        st_q   <= front_State;
      end else begin
        type_q <= '0;
      end
      if (ins_consume) begin
        ins_type_q <= CMD_IDLE;
        ins_sid_q  <= '0;
        ins_chid_q <= '0;
        ins_par_q  <= '0;
      end else begin
        ins_type_q <= back_InstructionType;
        ins_sid_q  <= back_InstructionStreamID;
        ins_chid_q <= back_InstructionChannelID;
        ins_par_q  <= back_InstructionParameter;
      end
    end
  end

  assign back_Data                  = data_q;
  assign back_Type                  = type_q;
  assign back_Last                  = last_q;
  assign back_StreamID              = sid_q;
  assign back_ChunkID               = cid_q;
  assign back_ChannelID             = chid_q;
  assign back_State                 = st_q;
  assign front_InstructionType      = ins_type_q;
  assign front_InstructionStreamID  = ins_sid_q;
  assign front_InstructionChannelID = ins_chid_q;
  assign front_InstructionParameter = ins_par_q;
  assign pausedMask                 = mask_q;
  assign dropCount                  = cnt_q;

endmodule

// File: tb/tb_stream_pause_gate.sv
// Scoreboard bench for stream_pause_gate: each driven cycle pushes its expected beat/instruction,
// which are popped and compared one cycle later.
module tb_stream_pause_gate;

  localparam int DW = 64;

  typedef struct packed {
    logic [1:0]  typ;
    logic [63:0] data;
    logic        last;
    logic [3:0]  sid;
    logic [4:0]  cid;
    logic [9:0]  chid;
    logic [31:0] st;
  } beat_t;

  typedef struct packed {
    logic [1:0]  typ;
    logic [3:0]  sid;
    logic [9:0]  chid;
    logic [15:0] par;
  } instr_t;

  logic        clk = 1'b0;
  logic        rstIn;
  logic [63:0] f_data, b_data;
  logic [1:0]  f_type, b_type;
  logic        f_last, b_last;
  logic [3:0]  f_sid, b_sid;
  logic [4:0]  f_cid, b_cid;
  logic [9:0]  f_chid, b_chid;
  logic [31:0] f_st, b_st;
  logic [1:0]  bi_type, fi_type;
  logic [3:0]  bi_sid, fi_sid;
  logic [9:0]  bi_chid, fi_chid;
  logic [15:0] bi_par, fi_par;
  logic [15:0] paused_mask;
  logic [1:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t  exp_beat_q[$];
  instr_t exp_ins_q[$];
  beat_t  last_pass;

  stream_pause_gate #(.DATA_WIDTH(DW), .DROP_COUNT_WIDTH(2)) dut (
    .clk(clk), .rstIn(rstIn),
    .front_Data(f_data), .front_Type(f_type), .front_Last(f_last), .front_StreamID(f_sid),
    .front_ChunkID(f_cid), .front_ChannelID(f_chid), .front_State(f_st),
    .back_Data(b_data), .back_Type(b_type), .back_Last(b_last), .back_StreamID(b_sid),
    .back_ChunkID(b_cid), .back_ChannelID(b_chid), .back_State(b_st),
    .back_InstructionType(bi_type), .back_InstructionStreamID(bi_sid),
    .back_InstructionChannelID(bi_chid), .back_InstructionParameter(bi_par),
    .front_InstructionType(fi_type), .front_InstructionStreamID(fi_sid),
    .front_InstructionChannelID(fi_chid), .front_InstructionParameter(fi_par),
    .pausedMask(paused_mask), .dropCount(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [3:0] sid, input logic last);
    beat_t b;
    b.typ  = 2'($urandom_range(1, 3));
    b.data = {$urandom, $urandom};
    b.last = last;
    b.sid  = sid;
    b.cid  = 5'($urandom);
    b.chid = 10'($urandom);
    b.st   = $urandom;
    return b;
  endfunction

  function automatic beat_t no_beat();
    beat_t b;
    b     = mk_beat(4'($urandom), 1'($urandom));
    b.typ = 2'b00;
    return b;
  endfunction

  function automatic instr_t mk_ins(input logic [1:0] typ, input logic [3:0] sid, input logic [9:0] chid);
    instr_t i;
    i.typ  = typ;
    i.sid  = sid;
    i.chid = chid;
    i.par  = 16'($urandom);
    return i;
  endfunction

  function automatic instr_t idle_ins();
    return mk_ins(2'd0, 4'($urandom), 10'($urandom));
  endfunction

  task automatic drive(input beat_t b, input instr_t ins);
    f_data = b.data; f_type = b.typ; f_last = b.last; f_sid = b.sid;
    f_cid = b.cid; f_chid = b.chid; f_st = b.st;
    bi_type = ins.typ; bi_sid = ins.sid; bi_chid = ins.chid; bi_par = ins.par;
  endtask

  task automatic compare_outputs();
    beat_t  eb;
    instr_t ei;
    eb = exp_beat_q.pop_front();
    ei = exp_ins_q.pop_front();
    check_val("back_Type", 64'(b_type), 64'(eb.typ));
    check_val("back_Data", b_data, eb.data);
    check_val("back_Last", 64'(b_last), 64'(eb.last));
    check_val("back_StreamID", 64'(b_sid), 64'(eb.sid));
    check_val("back_ChunkID", 64'(b_cid), 64'(eb.cid));
    check_val("back_ChannelID", 64'(b_chid), 64'(eb.chid));
    check_val("back_State", 64'(b_st), 64'(eb.st));
    check_val("ins_Type", 64'(fi_type), 64'(ei.typ));
    check_val("ins_StreamID", 64'(fi_sid), 64'(ei.sid));
    check_val("ins_ChannelID", 64'(fi_chid), 64'(ei.chid));
    check_val("ins_Parameter", 64'(fi_par), 64'(ei.par));
  endtask

  // pass: beat must appear on back_*; consumed: instruction must be swallowed.
  task automatic step(input beat_t b, input bit pass, input instr_t ins, input bit consumed);
    beat_t  eb;
    instr_t ei;
    drive(b, ins);
    if (pass) begin
      eb        = b;
      last_pass = b;
    end else begin
      eb     = last_pass;
      eb.typ = 2'b00;
    end
    ei = consumed ? instr_t'('0) : ins;
    exp_beat_q.push_back(eb);
    exp_ins_q.push_back(ei);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic rst_pulse(input beat_t b, input instr_t ins);
    rstIn = 1'b1;
    drive(b, ins);
    @(posedge clk);
    #1;
    check_val("rst_back_Type", 64'(b_type), 64'd0);
    check_val("rst_back_Data", b_data, 64'd0);
    check_val("rst_back_fields", 64'({b_last, b_sid, b_cid, b_chid, b_st}), 64'd0);
    check_val("rst_ins", 64'({fi_type, fi_sid, fi_chid, fi_par}), 64'd0);
    check_val("rst_pausedMask", 64'(paused_mask), 64'd0);
    check_val("rst_dropCount", 64'(drop_count), 64'd0);
    rstIn     = 1'b0;
    last_pass = '0;
  endtask

  initial begin
    rstIn = 1'b1;
    drive('0, '0);
    last_pass = '0;
    @(posedge clk);
    #1;
    // T1: reset state, then a 3-beat packet on stream 2
    rst_pulse(mk_beat(4'd2, 1'b0), mk_ins(2'd1, 4'd5, 10'd1023));
    step(mk_beat(4'd2, 1'b0), 1, idle_ins(), 0);
    step(mk_beat(4'd2, 1'b0), 1, idle_ins(), 0);
    step(mk_beat(4'd2, 1'b1), 1, idle_ins(), 0);
    step(no_beat(), 0, idle_ins(), 0);
    check_val("t1_dropCount", 64'(drop_count), 64'd0);

    // T2: pause stream 5, its packet is dropped, stream 3 passes
    step(no_beat(), 0, mk_ins(2'd1, 4'd5, 10'd1023), 1);
    check_val("t2_pausedMask", 64'(paused_mask), 64'h0020);
    step(mk_beat(4'd5, 1'b0), 0, idle_ins(), 0);
    step(mk_beat(4'd5, 1'b1), 0, idle_ins(), 0);
    step(mk_beat(4'd3, 1'b1), 1, idle_ins(), 0);
    check_val("t2_dropCount", 64'(drop_count), 64'd1);

    // T3: pause s4 on the packet's first beat; later beats ignore StreamID (s5 is paused)
    step(mk_beat(4'd4, 1'b0), 1, mk_ins(2'd1, 4'd4, 10'd1023), 1);
    step(mk_beat(4'd5, 1'b0), 1, idle_ins(), 0);
    step(no_beat(), 0, idle_ins(), 0);
    step(mk_beat(4'd4, 1'b0), 1, idle_ins(), 0);
    step(mk_beat(4'd4, 1'b1), 1, idle_ins(), 0);
    check_val("t3_pausedMask", 64'(paused_mask), 64'h0030);
    check_val("t3_dropCount_mid", 64'(drop_count), 64'd1);
    step(mk_beat(4'd4, 1'b0), 0, idle_ins(), 0);
    step(mk_beat(4'd4, 1'b1), 0, idle_ins(), 0);
    check_val("t3_dropCount", 64'(drop_count), 64'd2);

    // T4: resume s4 in the middle of a dropped s4 packet
    step(mk_beat(4'd4, 1'b0), 0, idle_ins(), 0);
    step(mk_beat(4'd4, 1'b0), 0, mk_ins(2'd2, 4'd4, 10'd1023), 1);
    check_val("t4_pausedMask", 64'(paused_mask), 64'h0020);
    step(no_beat(), 0, idle_ins(), 0);
    step(mk_beat(4'd4, 1'b1), 0, idle_ins(), 0);
    check_val("t4_dropCount", 64'(drop_count), 64'd3);
    step(mk_beat(4'd4, 1'b1), 1, idle_ins(), 0);

    // T5: instructions not addressed to the gate pass through; redundant ones are still consumed
    step(no_beat(), 0, mk_ins(2'd1, 4'd1, 10'd7), 0);
    step(no_beat(), 0, mk_ins(2'd3, 4'd2, 10'd1023), 0);
    step(no_beat(), 0, mk_ins(2'd2, 4'd5, 10'd1022), 0);
    check_val("t5_pausedMask_fwd", 64'(paused_mask), 64'h0020);
    step(mk_beat(4'd9, 1'b1), 1, mk_ins(2'd2, 4'd9, 10'd1023), 1);
    step(no_beat(), 0, mk_ins(2'd1, 4'd5, 10'd1023), 1);
    check_val("t5_pausedMask_redund", 64'(paused_mask), 64'h0020);

    // T6: counter saturation at 3, then reset in the middle of packets
    rst_pulse(no_beat(), idle_ins());
    step(no_beat(), 0, mk_ins(2'd1, 4'd6, 10'd1023), 1);
    for (int i = 0; i < 5; i++) begin
      step(mk_beat(4'd6, 1'b1), 0, idle_ins(), 0);
      check_val("t6_dropCount_sat", 64'(drop_count), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    step(mk_beat(4'd6, 1'b0), 0, idle_ins(), 0);
    rst_pulse(mk_beat(4'd6, 1'b0), mk_ins(2'd1, 4'd2, 10'd1023));
    step(mk_beat(4'd6, 1'b1), 1, idle_ins(), 0);
    check_val("t6_dropCount_after_rst", 64'(drop_count), 64'd0);
    step(mk_beat(4'd2, 1'b0), 1, idle_ins(), 0);
    rst_pulse(mk_beat(4'd2, 1'b0), idle_ins());
    step(mk_beat(4'd7, 1'b1), 1, mk_ins(2'd1, 4'd7, 10'd1023), 1);
    step(mk_beat(4'd7, 1'b1), 0, idle_ins(), 0);
    check_val("t6_dropCount_end", 64'(drop_count), 64'd1);
    check_val("t6_pausedMask_end", 64'(paused_mask), 64'h0080);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
